sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - boot-loader / CPU arbiter for an asynchronous byte-wide SRAM
`timescale 1ns/1ps

module sram_arbiter #(
    parameter logic [17:0] BOOT_START_ADDR = 18'h0C000,
    parameter logic [17:0] BOOT_END_ADDR   = 18'h0FFFF,
    parameter int          WR_CYCLES       = 2,
    parameter int          RD_CYCLES       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_valid,
    input  logic [7:0]  boot_data,
    output logic        boot_ready,
    output logic        boot_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [17:0] ADR,
    output logic [7:0]  DAT_out,
    output logic        DAT_oe,
    input  logic [7:0]  DAT_in,
    output logic        RAMCS_b,
    output logic        RAMOE_b,
    output logic        RAMWE_b
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_READ,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [17:0]    r_boot_addr;
    logic           r_boot_done;
    logic           r_boot_owner;
    logic [17:0]    r_adr;
    logic [7:0]     r_dat_out;
    logic           r_dat_oe;
    logic [7:0]     r_rdata;
    logic           r_ack;
    logic           r_cs_b;
    logic           r_oe_b;
    logic           r_we_b;
    logic           w_boot_take;

    // Boot byte is accepted in the same IDLE cycle it is offered; boot always beats the CPU
    always_comb begin
        w_boot_take = (r_state == S_IDLE) && boot_valid && !r_boot_done && !reset;
    end

    assign boot_ready = w_boot_take;
    assign boot_done  = r_boot_done;
    assign cpu_rdata  = r_rdata;
    assign cpu_ack    = r_ack;
    assign ADR        = r_adr;
    assign DAT_out    = r_dat_out;
    assign DAT_oe     = r_dat_oe;
    assign RAMCS_b    = r_cs_b;
    assign RAMOE_b    = r_oe_b;
    assign RAMWE_b    = r_we_b;

    // Access sequencer: strobes and ack are registered so each state's outputs appear for that state's cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_boot_addr  <= BOOT_START_ADDR;
            r_boot_done  <= 1'b0;
            r_boot_owner <= 1'b0;
            r_adr        <= '0;
            r_dat_out    <= '0;
            r_dat_oe     <= 1'b0;
            r_rdata      <= '0;
            r_ack        <= 1'b0;
            r_cs_b       <= 1'b1;
            r_oe_b       <= 1'b1;
            r_we_b       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_boot_take) begin
                        r_adr        <= r_boot_addr;
                        r_dat_out    <= boot_data;
                        r_boot_owner <= 1'b1;
                        r_cs_b       <= 1'b0;
                        r_dat_oe     <= 1'b1;
                        r_state      <= S_SETUP;
                    end else if (cpu_req) begin
                        r_adr        <= cpu_addr;
                        r_boot_owner <= 1'b0;
                        r_cs_b       <= 1'b0;
                        if (cpu_we) begin
                            r_dat_out <= cpu_wdata;
                            r_dat_oe  <= 1'b1;
                            r_state   <= S_SETUP;
                        end else begin
                            // Pads released in the same edge that OE drops, so the bus is never fought
                            r_oe_b    <= 1'b0;
                            r_dat_oe  <= 1'b0;
                            r_cnt     <= CW'(RD_CYCLES - 1);
                            r_state   <= S_READ;
                        end
                    end
                end
                S_SETUP: begin
                    r_we_b  <= 1'b0;
                    r_cnt   <= CW'(WR_CYCLES - 1);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_cnt == '0) begin
                        r_we_b  <= 1'b1;
                        r_ack   <= !r_boot_owner;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    r_cs_b   <= 1'b1;
                    r_dat_oe <= 1'b0;
                    r_ack    <= 1'b0;
                    r_state  <= S_IDLE;
                    // Boot pointer only advances once the byte is fully written; it parks at the end address
                    if (r_boot_owner) begin
                        if (r_boot_addr == BOOT_END_ADDR) begin
                            r_boot_done <= 1'b1;
                        end else begin
                            r_boot_addr <= r_boot_addr + 18'd1;
                        end
                    end
                end
                S_READ: begin
                    if (r_cnt == '0) begin
                        r_rdata <= DAT_in;
                        r_cs_b  <= 1'b1;
                        r_oe_b  <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cs_b   <= 1'b1;
                    r_oe_b   <= 1'b1;
                    r_we_b   <= 1'b1;
                    r_dat_oe <= 1'b0;
                    r_ack    <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with behavioural SRAM and reference memory
`timescale 1ns/1ps

module tb_sram_arbiter;

    localparam logic [17:0] BS  = 18'h0C000;
    localparam logic [17:0] BE  = 18'h0FFFF;
    localparam int          WRC = 2;
    localparam int          RDC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_valid;
    logic [7:0]  boot_data;
    logic        boot_ready;
    logic        boot_done;
    logic        cpu_req;
    logic        cpu_we;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [17:0] ADR;
    logic [7:0]  DAT_out;
    logic        DAT_oe;
    logic [7:0]  DAT_in;
    logic        RAMCS_b;
    logic        RAMOE_b;
    logic        RAMWE_b;

    always #5 clk = ~clk;

    sram_arbiter #(
        .BOOT_START_ADDR (BS),
        .BOOT_END_ADDR   (BE),
        .WR_CYCLES       (WRC),
        .RD_CYCLES       (RDC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .boot_valid (boot_valid),
        .boot_data  (boot_data),
        .boot_ready (boot_ready),
        .boot_done  (boot_done),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .ADR        (ADR),
        .DAT_out    (DAT_out),
        .DAT_oe     (DAT_oe),
        .DAT_in     (DAT_in),
        .RAMCS_b    (RAMCS_b),
        .RAMOE_b    (RAMOE_b),
        .RAMWE_b    (RAMWE_b)
    );

    logic [7:0]  mem     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic [17:0] bptr;
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic       rd;
        logic [7:0] d;
        int         issue;
        int         lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_e;
    logic [17:0] we_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM read path
    always_comb begin
        DAT_in = (!RAMCS_b && !RAMOE_b) ? mem[ADR] : 8'hEE;
    end

    // Protocol monitor and SRAM write model (write commits on WE rising edge with CS still low)
    logic        p_we = 1'b1;
    logic        p_oe = 1'b1;
    int          we_len, oe_len, we_gap;
    logic [17:0] we_adr;
    logic        adr_ok;
    logic        seen_rise;
    logic [17:0] last_we_addr;
    always @(negedge clk) begin
        if (reset) begin
            p_we = 1'b1; p_oe = 1'b1; we_len = 0; oe_len = 0; seen_rise = 1'b0;
        end else begin
            chk("we_oe_overlap", {31'd0, (!RAMWE_b && !RAMOE_b)}, 32'd0);
            chk("dat_oe_during_oe", {31'd0, (!RAMOE_b && DAT_oe)}, 32'd0);
            if (!RAMWE_b) begin
                if (p_we) begin
                    we_len = 1; we_adr = ADR; adr_ok = 1'b1; last_we_addr = ADR;
                    we_log.push_back(ADR);
                    if (seen_rise) chk("we_gap_ge2", {31'd0, (we_gap >= 2)}, 32'd1);
                end else begin
                    we_len++;
                    if (ADR !== we_adr) adr_ok = 1'b0;
                end
            end else begin
                if (!p_we) begin
                    chk("we_width", we_len, WRC);
                    chk("adr_stable_we", {31'd0, adr_ok}, 32'd1);
                    seen_rise = 1'b1; we_gap = 1;
                    if (!RAMCS_b) mem[ADR] = DAT_out;
                end else begin
                    we_gap++;
                end
            end
            if (!RAMOE_b) oe_len = p_oe ? 1 : oe_len + 1;
            else if (!p_oe) chk("oe_width", oe_len, RDC);
            p_we = RAMWE_b; p_oe = RAMOE_b;
        end
    end

    // Scoreboard monitor: every ack pops one expected CPU response
    always @(negedge clk) begin
        if (!reset && cpu_ack) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ack: got ack with no pending request (cycle %0d)", cyc);
            end else begin
                sb_e = sb.pop_front();
                if (sb_e.rd) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, sb_e.d});
                if (sb_e.lat != 0) chk("ack_latency", cyc - sb_e.issue, sb_e.lat);
            end
        end
    end

    // Issue one CPU access; call just after a rising edge. lat=0 means latency is not predicted.
    task automatic cpu_op(input logic we, input logic [17:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        int   n = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        e.rd = !we; e.d = we ? 8'h00 : ref_mem[a]; e.issue = cyc; e.lat = lat;
        sb.push_back(e);
        if (we) ref_mem[a] = d;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 200);
        if (!cpu_ack) begin
            checks++; failures++;
            $display("FAIL cpu_ack_timeout: got no ack expected ack within 200 cycles (addr 0x%0h)", a);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    // Offer one boot byte; call just after a rising edge
    task automatic send_boot(input logic [7:0] d);
        int n = 0;
        boot_valid = 1'b1; boot_data = d;
        do begin @(negedge clk); n++; end while (!boot_ready && n < 400);
        if (!boot_ready) begin
            checks++; failures++;
            $display("FAIL boot_ready_timeout: got no boot_ready expected one within 400 cycles");
        end else begin
            ref_mem[bptr] = d;
            bptr = bptr + 18'd1;
        end
        @(posedge clk); #1;
        boot_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: got no finish expected finish within 150000 cycles");
        $fatal(1);
    end

    initial begin
        int          n;
        int          nerr;
        int          rdy_cnt;
        logic [7:0]  last_b;
        logic [17:0] bstart;
        logic [7:0]  pat[4];

        for (int i = 0; i < 262144; i++) begin
            mem[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        bptr = BS;
        reset = 1'b1; boot_valid = 1'b0; boot_data = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {31'd0, RAMCS_b}, 32'd1);
        chk("rst_oe", {31'd0, RAMOE_b}, 32'd1);
        chk("rst_we", {31'd0, RAMWE_b}, 32'd1);
        chk("rst_dat_oe", {31'd0, DAT_oe}, 32'd0);
        chk("rst_adr", {14'd0, ADR}, 32'd0);
        chk("rst_dat_out", {24'd0, DAT_out}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_boot_ready", {31'd0, boot_ready}, 32'd0);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(2);

        // Short boot stream into the start of the boot window
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h3C; pat[3] = 8'hC3;
        for (int i = 0; i < 4; i++) send_boot(pat[i]);
        idle_cycles(6);
        for (int i = 0; i < 4; i++) chk("boot4_mem", {24'd0, mem[BS + 18'(i)]}, {24'd0, pat[i]});

        // Reads: boot data back, then an unwritten location
        cpu_op(1'b0, BS, 8'h00, RDC + 1);
        cpu_op(1'b0, 18'h000DE, 8'h00, RDC + 1);
        chk("rd_de_value", {24'd0, cpu_rdata}, 32'd0);
        idle_cycles(3);

        // Boot and CPU write offered in the same cycle: boot first, CPU ack after both accesses
        we_log.delete();
        bstart = bptr;
        fork
            send_boot(8'h6E);
            cpu_op(1'b1, 18'h000E0, 8'h12, 2 * WRC + 5);
        join
        idle_cycles(4);
        chk("prio_first_addr", {14'd0, we_log[0]}, {14'd0, bstart});
        chk("prio_second_addr", {14'd0, we_log[1]}, 32'h000E0);
        chk("prio_mem_e0", {24'd0, mem[18'h000E0]}, 32'h12);

        // Back-to-back CPU writes with request held, then read them back
        for (int i = 0; i < 4; i++) cpu_op(1'b1, 18'h00100 + 18'(i), 8'($urandom), WRC + 2);
        for (int i = 0; i < 4; i++) cpu_op(1'b0, 18'h00100 + 18'(i), 8'h00, RDC + 1);

        // Randomized mix of CPU traffic and boot bytes competing for the SRAM
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    cpu_op(1'($urandom), 18'($urandom_range(0, 255)), 8'($urandom), 0);
                    idle_cycles($urandom_range(0, 3));
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    send_boot(8'($urandom));
                    idle_cycles($urandom_range(0, 6));
                end
            end
        join
        idle_cycles(4);

        // Reset in the middle of a CPU write: strobes drop, no ack, boot pointer restarts
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h000A5; cpu_wdata = 8'h77;
        n = 0;
        do begin @(negedge clk); n++; end while (RAMWE_b && n < 50);
        chk("abort_we_seen", {31'd0, RAMWE_b}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_we", {31'd0, RAMWE_b}, 32'd1);
        chk("abort_cs", {31'd0, RAMCS_b}, 32'd1);
        chk("abort_oe", {31'd0, RAMOE_b}, 32'd1);
        chk("abort_dat_oe", {31'd0, DAT_oe}, 32'd0);
        chk("abort_ack", {31'd0, cpu_ack}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bptr = BS;
        idle_cycles(2);
        chk("abort_boot_done", {31'd0, boot_done}, 32'd0);
        send_boot(8'h99);
        idle_cycles(6);
        chk("restart_addr", {14'd0, last_we_addr}, {14'd0, BS});
        chk("restart_mem", {24'd0, mem[BS]}, 32'h99);

        // Remainder of the full boot window
        last_b = 8'h00;
        for (int i = 1; i < 16384; i++) begin
            last_b = 8'($urandom);
            send_boot(last_b);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (RAMWE_b && n < 20);
        do begin @(negedge clk); n++; end while (!RAMWE_b && n < 40);
        chk("last_hold_adr", {14'd0, ADR}, {14'd0, BE});
        chk("done_in_hold", {31'd0, boot_done}, 32'd0);
        @(negedge clk);
        chk("done_after_hold", {31'd0, boot_done}, 32'd1);
        chk("last_byte_mem", {24'd0, mem[BE]}, {24'd0, last_b});
        @(posedge clk); #1;
        boot_valid = 1'b1;
        rdy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (boot_ready) rdy_cnt++;
        end
        boot_valid = 1'b0;
        chk("no_ready_after_done", rdy_cnt, 0);
        chk("boot_done_sticky", {31'd0, boot_done}, 32'd1);

        // CPU still served after boot completes
        @(posedge clk); #1;
        cpu_op(1'b1, 18'h3FFFF, 8'h5C, WRC + 2);
        cpu_op(1'b0, 18'h3FFFF, 8'h00, RDC + 1);
        idle_cycles(4);

        nerr = 0;
        for (int i = 0; i < 262144; i++) if (mem[i] !== ref_mem[i]) nerr++;
        chk("mem_vs_model", nerr, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
